// File: rtl/rate_tracking_controller.sv
// Rate tracking controller: arms on an enable request, measures the interval
// between reference edges through an external rate accumulator, declares lock
// once enough consecutive periods agree, and reports glitches, timeouts and loss of lock.
module rate_tracking_controller #(
   parameter int unsigned RATE_COUNTER_WIDTH = 16,
   parameter int unsigned MIN_PERIOD         = 4,
   parameter int unsigned MAX_PERIOD         = 1000,
   parameter int unsigned TOLERANCE          = 2,
   parameter int unsigned LOCK_COUNT         = 4
) (
   input  logic                          clk,
   input  logic                          sync_rst_n,
   input  logic                          clk_en,
   input  logic                          enable_i,
   input  logic                          edge_i,
   input  logic [RATE_COUNTER_WIDTH-1:0] rate_accumulator_i,
   output logic                          rate_tracking_en_o,
   output logic                          clear_state_o,
   output logic                          clear_rate_o,
   output logic                          update_rate_o,
   output logic                          locked_o,
   output logic                          timeout_o,
   output logic                          glitch_o,
   output logic                          lost_lock_o,
   output logic [1:0]                    state_o
);

   localparam int unsigned W  = RATE_COUNTER_WIDTH;
   localparam int unsigned DW = RATE_COUNTER_WIDTH + 1;
   localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;
   localparam logic [1:0] LOCKED  = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] match_cnt, match_cnt_nxt, match_cnt_inc;
   logic [W-1:0]  prev_rate, prev_rate_nxt;
   logic [DW-1:0] acc_ext, prev_ext, diff;
   logic          period_match;
   logic          update_c, clear_rate_c, timeout_c, glitch_c, lost_lock_c;

   // Absolute period difference, one bit wider so it never wraps
   always_comb begin
      acc_ext       = {1'b0, rate_accumulator_i};
      prev_ext      = {1'b0, prev_rate};
      diff          = (acc_ext >= prev_ext) ? (acc_ext - prev_ext) : (prev_ext - acc_ext);
      period_match  = (diff <= DW'(TOLERANCE)) && (prev_rate != '0);
      match_cnt_inc = (match_cnt == CW'(LOCK_COUNT)) ? match_cnt : (match_cnt + CW'(1));
   end

   // Next-state, counter and strobe decode
   always_comb begin
      state_nxt     = state;
      match_cnt_nxt = match_cnt;
      prev_rate_nxt = prev_rate;
      update_c      = 1'b0;
      clear_rate_c  = 1'b0;
      timeout_c     = 1'b0;
      glitch_c      = 1'b0;
      lost_lock_c   = 1'b0;
      if (clk_en) begin
         if (!enable_i) begin
            state_nxt     = IDLE;
            match_cnt_nxt = '0;
            prev_rate_nxt = '0;
         end else begin
            case (state)
               IDLE: state_nxt = ARM;
               ARM: begin
                  if (edge_i) begin
                     state_nxt     = MEASURE;
                     match_cnt_nxt = '0;
                     prev_rate_nxt = '0;
                     clear_rate_c  = 1'b1;
                  end
               end
               default: begin
                  if (edge_i) begin
                     if (rate_accumulator_i >= W'(MIN_PERIOD)) begin
                        update_c      = 1'b1;
                        prev_rate_nxt = rate_accumulator_i;
                        match_cnt_nxt = period_match ? match_cnt_inc : '0;
                        if (state == MEASURE && period_match &&
                            match_cnt_inc == CW'(LOCK_COUNT)) begin
                           state_nxt = LOCKED;
                        end else if (state == LOCKED && !period_match) begin
                           state_nxt   = MEASURE;
                           lost_lock_c = 1'b1;
                        end
                     end else begin
                        glitch_c = 1'b1;
                     end
                  end else if (rate_accumulator_i >= W'(MAX_PERIOD)) begin
                     timeout_c     = 1'b1;
                     clear_rate_c  = 1'b1;
                     lost_lock_c   = (state == LOCKED);
                     state_nxt     = ARM;
                     match_cnt_nxt = '0;
                     prev_rate_nxt = '0;
                  end
               end
            endcase
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Measurement history, lock flag and event pulses
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         match_cnt   <= '0;
         prev_rate   <= '0;
         locked_o    <= 1'b0;
         timeout_o   <= 1'b0;
         glitch_o    <= 1'b0;
         lost_lock_o <= 1'b0;
      end else begin
         match_cnt   <= match_cnt_nxt;
         prev_rate   <= prev_rate_nxt;
         locked_o    <= (state_nxt == LOCKED);
         timeout_o   <= timeout_c;
         glitch_o    <= glitch_c;
         lost_lock_o <= lost_lock_c;
      end
   end

   // Tracker control strobes; reset forces the tracker idle and cleared
   always_comb begin
      rate_tracking_en_o = sync_rst_n && (state != IDLE);
      clear_state_o      = !sync_rst_n || (state == IDLE);
      clear_rate_o       = sync_rst_n && clear_rate_c;
      update_rate_o      = sync_rst_n && update_c;
   end

   assign state_o = state;

endmodule

// File: tb/tb_rate_tracking_controller.sv
// Bench for rate_tracking_controller: directed scenarios followed by random
// traffic, all checked against a period-streak reference model.
module tb_rate_tracking_controller;

   localparam int MIN_P = 4;
   localparam int MAX_P = 1000;
   localparam int TOL   = 2;
   localparam int LOCKN = 4;

   localparam int S_IDLE = 0;
   localparam int S_ARM  = 1;
   localparam int S_MEAS = 2;
   localparam int S_LOCK = 3;

   logic        clk = 1'b0;
   logic        sync_rst_n, clk_en, enable_i, edge_i;
   logic [15:0] rate_accumulator_i;
   logic        rate_tracking_en_o, clear_state_o, clear_rate_o, update_rate_o;
   logic        locked_o, timeout_o, glitch_o, lost_lock_o;
   logic [1:0]  state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: phase, count of consecutive matching periods, last period
   int m_state  = S_IDLE;
   int m_streak = 0;
   int m_prev   = 0;

   rate_tracking_controller #(
      .RATE_COUNTER_WIDTH(16),
      .MIN_PERIOD(MIN_P),
      .MAX_PERIOD(MAX_P),
      .TOLERANCE(TOL),
      .LOCK_COUNT(LOCKN)
   ) dut (
      .clk(clk),
      .sync_rst_n(sync_rst_n),
      .clk_en(clk_en),
      .enable_i(enable_i),
      .edge_i(edge_i),
      .rate_accumulator_i(rate_accumulator_i),
      .rate_tracking_en_o(rate_tracking_en_o),
      .clear_state_o(clear_state_o),
      .clear_rate_o(clear_rate_o),
      .update_rate_o(update_rate_o),
      .locked_o(locked_o),
      .timeout_o(timeout_o),
      .glitch_o(glitch_o),
      .lost_lock_o(lost_lock_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational strobes, advance model, check registers
   task automatic do_cycle(input bit rst, input bit ce, input bit en, input bit ed, input int acc);
      bit active, qual, accepted, to;
      bit e_to, e_gl, e_lost;
      int d;
      bit m;
      @(negedge clk);
      sync_rst_n         = rst;
      clk_en             = ce;
      enable_i           = en;
      edge_i             = ed;
      rate_accumulator_i = 16'(acc);
      #1;
      active   = rst && ce && en;
      qual     = active && ed && (m_state != S_IDLE);
      accepted = qual && (m_state == S_ARM || acc >= MIN_P);
      to       = active && !ed && (m_state >= S_MEAS) && (acc >= MAX_P);
      chk("clear_state", 32'(clear_state_o), 32'(!rst || m_state == S_IDLE));
      chk("rate_en", 32'(rate_tracking_en_o), 32'(rst && m_state != S_IDLE));
      chk("update_rate", 32'(update_rate_o), 32'(accepted && m_state >= S_MEAS));
      chk("clear_rate", 32'(clear_rate_o), 32'((accepted && m_state == S_ARM) || to));

      e_to = 0; e_gl = 0; e_lost = 0;
      if (!rst) begin
         m_state = S_IDLE; m_streak = 0; m_prev = 0;
      end else if (ce) begin
         if (!en) begin
            m_state = S_IDLE; m_streak = 0; m_prev = 0;
         end else if (m_state == S_IDLE) begin
            m_state = S_ARM;
         end else if (m_state == S_ARM) begin
            if (ed) begin
               m_state = S_MEAS; m_streak = 0; m_prev = 0;
            end
         end else if (ed) begin
            if (acc < MIN_P) begin
               e_gl = 1;
            end else begin
               d = (acc > m_prev) ? acc - m_prev : m_prev - acc;
               m = (d <= TOL) && (m_prev != 0);
               m_prev   = acc;
               m_streak = m ? m_streak + 1 : 0;
               if (m_state == S_LOCK && !m) begin
                  e_lost  = 1;
                  m_state = S_MEAS;
               end else if (m_state == S_MEAS && m_streak >= LOCKN) begin
                  m_state = S_LOCK;
               end
            end
         end else if (to) begin
            e_to   = 1;
            e_lost = (m_state == S_LOCK);
            m_state = S_ARM; m_streak = 0; m_prev = 0;
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      chk("state", 32'(state_o), 32'(m_state));
      chk("locked", 32'(locked_o), 32'(m_state == S_LOCK));
      chk("timeout", 32'(timeout_o), 32'(e_to));
      chk("glitch", 32'(glitch_o), 32'(e_gl));
      chk("lost_lock", 32'(lost_lock_o), 32'(e_lost));
   endtask

   task automatic gap_edge(input int p);
      do_cycle(1, 1, 1, 0, p / 2);
      do_cycle(1, 1, 1, 1, p);
   endtask

   initial begin
      int sel, acc;
      sync_rst_n = 1'b0; clk_en = 1'b0; enable_i = 1'b0; edge_i = 1'b0;
      rate_accumulator_i = '0;

      // reset state
      do_cycle(0, 1, 0, 0, 0);
      do_cycle(0, 0, 1, 1, 500);
      chk("reset_state", 32'(state_o), 32'(S_IDLE));
      chk("reset_clear_state", 32'(clear_state_o), 32'd1);
      do_cycle(1, 1, 0, 0, 0);
      do_cycle(1, 1, 1, 0, 0);
      chk("idle_to_arm", 32'(state_o), 32'(S_ARM));

      // lock acquisition
      do_cycle(1, 1, 1, 1, 37);
      chk("arm_to_measure", 32'(state_o), 32'(S_MEAS));
      for (int i = 0; i < 5; i++) gap_edge(100);
      chk("lock_acquired", 32'(locked_o), 32'd1);

      // tolerance boundary
      gap_edge(102);
      gap_edge(103);
      chk("tol_boundary_locked", 32'(locked_o), 32'd1);
      gap_edge(106);
      chk("tol_exceeded_lost", 32'(lost_lock_o), 32'd1);
      chk("tol_exceeded_state", 32'(state_o), 32'(S_MEAS));

      // timeout while locked
      for (int i = 0; i < 4; i++) gap_edge(106);
      chk("relock", 32'(locked_o), 32'd1);
      do_cycle(1, 1, 1, 0, 1000);
      chk("timeout_pulse", 32'(timeout_o), 32'd1);
      chk("timeout_lost", 32'(lost_lock_o), 32'd1);
      chk("timeout_state", 32'(state_o), 32'(S_ARM));

      // glitch leaves history untouched, edge/timeout collision
      do_cycle(1, 1, 1, 1, 50);
      gap_edge(100);
      do_cycle(1, 1, 1, 1, 3);
      chk("glitch_pulse", 32'(glitch_o), 32'd1);
      for (int i = 0; i < 4; i++) gap_edge(101);
      chk("glitch_prev_kept", 32'(locked_o), 32'd1);
      do_cycle(1, 1, 1, 1, 1000);
      chk("collision_no_timeout", 32'(timeout_o), 32'd0);

      // clock enable low holds everything
      do_cycle(1, 0, 0, 1, 1000);
      do_cycle(1, 0, 1, 0, 2000);
      chk("clk_en_hold", 32'(state_o), 32'(S_MEAS));

      // disable from LOCKED
      for (int i = 0; i < 5; i++) gap_edge(100);
      do_cycle(1, 1, 0, 0, 50);
      chk("disable_state", 32'(state_o), 32'(S_IDLE));
      chk("disable_clear_state", 32'(clear_state_o), 32'd1);
      chk("disable_rate_en", 32'(rate_tracking_en_o), 32'd0);

      // reset mid-measurement and recovery
      do_cycle(1, 1, 1, 0, 0);
      do_cycle(1, 1, 1, 1, 20);
      gap_edge(100);
      do_cycle(0, 1, 1, 1, 100);
      chk("midreset_state", 32'(state_o), 32'(S_IDLE));
      do_cycle(1, 1, 1, 0, 0);
      chk("recover_arm", 32'(state_o), 32'(S_ARM));

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0:       acc = int'($urandom_range(0, 10));
            1, 2:    acc = int'($urandom_range(95, 110));
            3:       acc = int'($urandom_range(990, 1010));
            default: acc = int'($urandom_range(0, 65535));
         endcase
         do_cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) == 0),
                  acc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rate_tracking_controller.md
RATE_TRACKING_CONTROLLER -- requirements
Module: rate_tracking_controller

Interface
REQ-001 SHALL have parameter RATE_COUNTER_WIDTH, default 16: width of the rate accumulator and rate values.
REQ-002 SHALL have parameter MIN_PERIOD, default 4: smallest accepted edge-to-edge count; shorter intervals are glitches.
REQ-003 SHALL have parameter MAX_PERIOD, default 1000: accumulator value at which an edge timeout is declared.
REQ-004 SHALL have parameter TOLERANCE, default 2: maximum absolute difference between consecutive periods that counts as a match.
REQ-005 SHALL have parameter LOCK_COUNT, default 4 (minimum 1): consecutive matches required to lock.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-007 SHALL have port sync_rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port clk_en, input, 1: clock enable; state updates only when clk_en=1.
REQ-009 SHALL have port enable_i, input, 1: tracking enable request.
REQ-010 SHALL have port edge_i, input, 1: single-cycle reference-edge event.
REQ-011 SHALL have port rate_accumulator_i, input, RATE_COUNTER_WIDTH: live rate accumulator count.
REQ-012 SHALL have port rate_tracking_en_o, input-to-tracker, output, 1: accumulator run enable.
REQ-013 SHALL have ports clear_state_o, clear_rate_o and update_rate_o, each output, 1: tracker control strobes.
REQ-014 SHALL have port locked_o, output, 1: registered lock indication.
REQ-015 SHALL have ports timeout_o, glitch_o and lost_lock_o, each output, 1: registered single-cycle event pulses.
REQ-016 SHALL have port state_o, output, 2: current FSM state, encoded IDLE=0, ARM=1, MEASURE=2, LOCKED=3.

Function
REQ-017 SHALL decode rate_tracking_en_o combinationally from state as 1 in ARM, MEASURE and LOCKED, and 0 in IDLE.
REQ-018 SHALL assert clear_state_o combinationally in IDLE, and also while sync_rst_n=0.
REQ-019 SHALL define a qualified edge as edge_i & clk_en in ARM, MEASURE or LOCKED.
REQ-020 SHALL define an accepted edge as a qualified edge with rate_accumulator_i >= MIN_PERIOD; the ARM state has no minimum.
REQ-021 SHALL define timeout as clk_en & rate_accumulator_i >= MAX_PERIOD & no qualified edge, in MEASURE or LOCKED.
REQ-022 SHALL assert update_rate_o combinationally, in the same cycle, for every accepted edge in MEASURE or LOCKED.
REQ-023 SHALL assert clear_rate_o combinationally for an accepted edge in ARM, and on timeout.
REQ-024 SHALL, in IDLE, move to ARM when enable_i=1 and clk_en=1.
REQ-025 SHALL, in ARM, move to MEASURE on the first qualified edge and clear match_cnt and prev_rate.
REQ-026 SHALL, in MEASURE or LOCKED on an accepted edge, compute diff = |rate_accumulator_i - prev_rate| at RATE_COUNTER_WIDTH+1 bits, unsigned, with no wrap.
REQ-027 SHALL, for that accepted edge, increment match_cnt (saturating) if diff <= TOLERANCE and prev_rate != 0; otherwise match_cnt SHALL be set to 0.
REQ-028 SHALL load prev_rate with rate_accumulator_i on that accepted edge.
REQ-029 SHALL, in MEASURE, move to LOCKED when the updated match_cnt equals LOCK_COUNT.
REQ-030 SHALL, in LOCKED, on a mismatching accepted edge, move to MEASURE with match_cnt=0 and pulse lost_lock_o.
REQ-031 SHALL, on a qualified edge that is not accepted in MEASURE or LOCKED, pulse glitch_o, leave state, match_cnt and prev_rate unchanged, and issue no strobes.
REQ-032 SHALL, on timeout, move to ARM, clear match_cnt and prev_rate, and pulse timeout_o; if the state was LOCKED it SHALL also pulse lost_lock_o.
REQ-033 SHALL give edge priority over timeout when both occur in the same cycle.
REQ-034 SHALL move from any state to IDLE when enable_i=0 and clk_en=1, with priority over all other transitions, and SHALL clear match_cnt and prev_rate.
REQ-035 SHALL register locked_o as (next state == LOCKED), so it rises one cycle after the locking edge.
REQ-036 SHALL drive each event pulse high for exactly one clk cycle after its cause, then return it to 0.
REQ-037 SHALL hold all state, outputs and counters when clk_en=0, and SHALL hold all strobes at 0.

Reset
REQ-038 SHALL, when sync_rst_n=0 at a clock edge regardless of clk_en, set state=IDLE, match_cnt=0, prev_rate=0, locked_o=0, and timeout_o, glitch_o and lost_lock_o to 0.
REQ-039 SHALL, while sync_rst_n=0, hold rate_tracking_en_o, update_rate_o and clear_rate_o at 0 and clear_state_o at 1.
REQ-040 SHALL, on a reset asserted mid-measurement, abandon the measurement; no strobe other than clear_state_o SHALL be issued in the reset cycle.

Verification
REQ-041 SHALL cover lock acquisition: clk_en=1, enable_i=1, edges every 100 cycles (accumulator 100) -> ARM, then MEASURE; update_rate_o on each accepted edge; locked_o=1 one cycle after the 5th accepted edge.
REQ-042 SHALL cover the tolerance boundary: periods 100, 102 and 103 are matches; a jump to 106 -> lost_lock_o pulse, state MEASURE, locked_o=0.
REQ-043 SHALL cover timeout: while locked, no edge until the accumulator reaches 1000 -> timeout_o and lost_lock_o pulse, clear_rate_o=1, state ARM.
REQ-044 SHALL cover glitch and collision: edge at accumulator 3 -> glitch_o only, with prev_rate unchanged; edge at accumulator 1000 -> update_rate_o, no timeout_o.
REQ-045 SHALL cover disable: enable_i dropped in LOCKED -> IDLE next cycle, clear_state_o=1, rate_tracking_en_o=0, locked_o=0.
REQ-046 SHALL cover reset: sync_rst_n=0 in MEASURE -> next cycle IDLE with all event outputs 0, clear_state_o=1 during reset; recovery to ARM on enable_i=1.
